dac_burst_sequencer: RTL and testbench

Burst scheduler for the segmented current-steering DAC waveform generator. It accepts a start command with burst configuration and gates the generator through `o_gen_hold` so that whole 10-phase waveform periods are emitted in bursts, separated by idle gaps. It also latches the DEM-disable setting and reports progress and completion to the control side. It sits between the configuration/control logic and the generator; `o_gen_hold` drives the generator's reset, and `o_dem_dis` drives its DEM-disable input.

---
 rtl/dac_seq_pkg.sv | 13 +
 rtl/dac_phase_cnt.sv | 33 +++
 rtl/dac_burst_sequencer.sv | 144 ++++++++++++++
 tb/tb_dac_burst_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dac_seq_pkg.sv
// Shared types and defaults for the DAC burst sequencer.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int PERIOD_LEN_DEFAULT = 10;

endpackage

// File: rtl/dac_phase_cnt.sv
// Modulo-PERIOD_LEN phase counter kept in step with the generator ring.
module dac_phase_cnt #(
  parameter int PERIOD_LEN = 10
) (
  input  logic i_sys_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_last_phase
);

  localparam int PH_W = (PERIOD_LEN > 1) ? $clog2(PERIOD_LEN) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD_LEN - 1);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

  logic [PH_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (i_clear)
      phase_d = '0;
    else if (i_en)
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_ONE;
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) phase_q <= '0;
    else         phase_q <= phase_d;
  end

  assign o_last_phase = (phase_q == PH_LAST);

endmodule

// File: rtl/dac_burst_sequencer.sv
// Gates the DAC waveform generator into bursts of whole periods separated by idle gaps.
module dac_burst_sequencer
  import dac_seq_pkg::*;
#(
  parameter int PERIOD_LEN = PERIOD_LEN_DEFAULT,
  parameter int CNT_W      = 8
) (
  input  logic             i_sys_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_burst_len,
  input  logic [CNT_W-1:0] i_burst_num,
  input  logic [CNT_W-1:0] i_gap_len,
  input  logic             i_dem_dis_cfg,
  output logic             o_gen_hold,
  output logic             o_dem_dis,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_period_tick,
  output logic [CNT_W-1:0] o_burst_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
  logic [CNT_W-1:0] burst_num_q, burst_num_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic             dem_dis_q, dem_dis_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             abort_pend_q, abort_pend_d;
  logic             hold_q;

  logic             last_phase;
  logic             abort_req;
  logic             burst_end;
  logic [CNT_W-1:0] burst_cnt_inc;

  dac_phase_cnt #(.PERIOD_LEN(PERIOD_LEN)) u_phase_cnt (
    .i_sys_clk    (i_sys_clk),
    .i_reset      (i_reset),
    .i_clear      (state_q != ST_RUN),
    .i_en         (state_q == ST_RUN),
    .o_last_phase (last_phase)
  );

  // An abort arriving on the final phase itself still ends the run at that period.
  assign abort_req     = abort_pend_q | i_abort;
  assign burst_end     = (burst_len_q != '0) && (period_cnt_q == burst_len_q - CNT_ONE);
  assign burst_cnt_inc = burst_cnt_q + CNT_ONE;

  always_comb begin
    state_d      = state_q;
    burst_len_d  = burst_len_q;
    burst_num_d  = burst_num_q;
    gap_len_d    = gap_len_q;
    dem_dis_d    = dem_dis_q;
    period_cnt_d = period_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    abort_pend_d = abort_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (i_start) begin
          burst_len_d  = i_burst_len;
          burst_num_d  = i_burst_num;
          gap_len_d    = i_gap_len;
          dem_dis_d    = i_dem_dis_cfg;
          period_cnt_d = '0;
          burst_cnt_d  = '0;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_abort) abort_pend_d = 1'b1;
        if (last_phase) begin
          if (abort_req) begin
            state_d = ST_DONE;
          end else if (burst_end) begin
            burst_cnt_d  = burst_cnt_inc;
            period_cnt_d = '0;
            if ((burst_num_q != '0) && (burst_cnt_inc == burst_num_q)) begin
              state_d = ST_DONE;
            end else if (gap_len_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_len_q;
            end
          end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
          end
        end
      end
      ST_GAP: begin
        if (abort_req)                state_d   = ST_DONE;
        else if (gap_cnt_q == CNT_ONE) state_d   = ST_RUN;
        else                          gap_cnt_d = gap_cnt_q - CNT_ONE;
      end
      ST_DONE: begin
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      burst_len_q  <= '0;
      burst_num_q  <= '0;
      gap_len_q    <= '0;
      dem_dis_q    <= 1'b0;
      period_cnt_q <= '0;
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      abort_pend_q <= 1'b0;
      hold_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      burst_len_q  <= burst_len_d;
      burst_num_q  <= burst_num_d;
      gap_len_q    <= gap_len_d;
      dem_dis_q    <= dem_dis_d;
      period_cnt_q <= period_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      abort_pend_q <= abort_pend_d;
      hold_q       <= (state_d != ST_RUN);
    end
  end

  assign o_gen_hold    = hold_q;
  assign o_dem_dis     = dem_dis_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_period_tick = (state_q == ST_RUN) && last_phase;
  assign o_burst_cnt   = burst_cnt_q;

endmodule

// File: tb/tb_dac_burst_sequencer.sv
// Randomized and directed bench for dac_burst_sequencer against a timeline model.
module tb_dac_burst_sequencer;

  localparam int P     = 10;
  localparam int LIMIT = 200;

  logic       i_sys_clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic       i_abort;
  logic [7:0] i_burst_len;
  logic [7:0] i_burst_num;
  logic [7:0] i_gap_len;
  logic       i_dem_dis_cfg;
  logic       o_gen_hold;
  logic       o_dem_dis;
  logic       o_busy;
  logic       o_done;
  logic       o_period_tick;
  logic [7:0] o_burst_cnt;

  int total = 0;
  int bad   = 0;
  int run_id = 0;

  bit ex_hold[$];
  bit ex_tick[$];
  bit ex_be[$];

  dac_burst_sequencer #(.PERIOD_LEN(P), .CNT_W(8)) dut (
    .i_sys_clk     (i_sys_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_burst_len   (i_burst_len),
    .i_burst_num   (i_burst_num),
    .i_gap_len     (i_gap_len),
    .i_dem_dis_cfg (i_dem_dis_cfg),
    .o_gen_hold    (o_gen_hold),
    .o_dem_dis     (o_dem_dis),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_period_tick (o_period_tick),
    .o_burst_cnt   (o_burst_cnt)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Per-cycle timeline of a run, starting with the first cycle after the start edge.
  function automatic void build(input int len, input int num, input int gap);
    int b;
    int np;
    ex_hold.delete(); ex_tick.delete(); ex_be.delete();
    b  = 0;
    np = (len == 0) ? 1 : len;
    while (ex_hold.size() < LIMIT) begin
      for (int p = 0; p < np; p++)
        for (int ph = 0; ph < P; ph++) begin
          ex_hold.push_back(1'b0);
          ex_tick.push_back(ph == P - 1);
          ex_be.push_back(len != 0 && p == np - 1 && ph == P - 1);
        end
      if (len != 0) begin
        b++;
        if (num != 0 && b == num) break;
        for (int g = 0; g < gap; g++) begin
          ex_hold.push_back(1'b1);
          ex_tick.push_back(1'b0);
          ex_be.push_back(1'b0);
        end
      end
    end
  endfunction

  // Abort ends a gap immediately but lets the current period finish.
  function automatic void cut(input int ab);
    int c;
    if (ab < 0 || ab >= ex_hold.size()) return;
    c = ab;
    if (!ex_hold[ab])
      while (!ex_tick[c]) c++;
    ex_be[c] = 1'b0;
    while (ex_hold.size() > c + 1) begin
      void'(ex_hold.pop_back());
      void'(ex_tick.pop_back());
      void'(ex_be.pop_back());
    end
  endfunction

  task automatic run_check(input int len, input int num, input int gap, input int ab,
                           input bit dem, input bit noise);
    int n;
    logic [7:0]  bc;
    logic [12:0] exp;
    build(len, num, gap);
    cut(ab);
    n = ex_hold.size();
    run_id++;
    i_burst_len   = 8'(len);
    i_burst_num   = 8'(num);
    i_gap_len     = 8'(gap);
    i_dem_dis_cfg = dem;
    i_abort       = 1'b0;
    i_start       = 1'b1;
    @(posedge i_sys_clk); #1;
    i_start = 1'b0;
    bc = 8'd0;
    for (int k = 0; k < n + 2; k++) begin
      i_abort = (k == ab) || (noise && k == n + 1);
      if (noise && k <= n) begin
        i_start       = 1'($urandom_range(0, 1));
        i_burst_len   = 8'($urandom_range(0, 255));
        i_burst_num   = 8'($urandom_range(0, 255));
        i_gap_len     = 8'($urandom_range(0, 255));
        i_dem_dis_cfg = ~dem;
      end else begin
        i_start = 1'b0;
      end
      if (k < n)       exp = {ex_hold[k], ex_tick[k], 1'b0, 1'b1, dem, bc};
      else if (k == n) exp = {1'b1, 1'b0, 1'b1, 1'b1, dem, bc};
      else             exp = {1'b1, 1'b0, 1'b0, 1'b0, dem, bc};
      chk($sformatf("run%0d_cyc%0d", run_id, k),
          {o_gen_hold, o_period_tick, o_done, o_busy, o_dem_dis, o_burst_cnt}, exp);
      if (k < n && ex_be[k]) bc++;
      @(posedge i_sys_clk); #1;
    end
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  initial begin
    int len, num, gap, ab, sz, hi;
    i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0;
    i_burst_len = '0; i_burst_num = '0; i_gap_len = '0; i_dem_dis_cfg = 1'b0;
    #1;
    chk("reset_vals", {o_gen_hold, o_period_tick, o_done, o_busy, o_dem_dis, o_burst_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    @(posedge i_sys_clk); @(posedge i_sys_clk); #1;
    i_reset = 1'b0;
    @(posedge i_sys_clk); #1;

    run_check(2, 1, 0, -1, 1'b0, 1'b0);
    run_check(1, 3, 5, -1, 1'b1, 1'b0);
    run_check(0, 0, 0, 33, 1'b0, 1'b0);
    run_check(1, 3, 8, 11, 1'b0, 1'b0);
    run_check(1, 2, 0, -1, 1'b1, 1'b0);
    run_check(2, 2, 3, -1, 1'b1, 1'b1);
    run_check(1, 1, 0, -1, 1'b0, 1'b0);

    // Reset in the middle of a burst, then a clean run.
    i_burst_len = 8'd2; i_burst_num = 8'd1; i_gap_len = 8'd0; i_dem_dis_cfg = 1'b1;
    i_start = 1'b1;
    @(posedge i_sys_clk); #1;
    i_start = 1'b0;
    repeat (7) @(posedge i_sys_clk);
    #1;
    i_reset = 1'b1;
    #1;
    chk("reset_mid_burst", {o_gen_hold, o_period_tick, o_done, o_busy, o_dem_dis, o_burst_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    @(posedge i_sys_clk); #1;
    i_reset = 1'b0;
    @(posedge i_sys_clk); #1;
    run_check(2, 1, 0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      len = $urandom_range(0, 3);
      num = $urandom_range(0, 3);
      gap = $urandom_range(0, 6);
      build(len, num, gap);
      sz = ex_hold.size();
      if (len == 0 || num == 0) begin
        hi = (sz - 1 < 80) ? sz - 1 : 80;
        ab = $urandom_range(0, hi);
      end else begin
        ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, sz - 1)) : -1;
      end
      run_check(len, num, gap, ab, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
